jtpopeye_objbuf: RTL



---
 rtl/jtpopeye_pkg.sv | 17 +
 rtl/jtpopeye_objbuf_bank.sv | 24 ++
 rtl/jtpopeye_objbuf.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_pkg.sv
// Shared constants and types for the Popeye object line buffer.
// A buffer word is {objc[5:0], objv[1:0]}; objv == 0 marks a transparent pixel.
package jtpopeye_pkg;

  localparam int OBJ_AW = 9;
  localparam int OBJ_DW = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } objbuf_state_t;

  function automatic logic [1:0] obj_pxl_v(input logic [OBJ_DW-1:0] word);
    return word[1:0];
  endfunction

endpackage

// File: rtl/jtpopeye_objbuf_bank.sv
// One line bank: 2^AW x DATA_W simple dual-port RAM, synchronous read-first.
// A read and a write to the same address on one edge return the old word.
module jtpopeye_objbuf_bank
  import jtpopeye_pkg::*;
#(
  parameter int AW     = OBJ_AW,
  parameter int DATA_W = OBJ_DW
) (
  input  logic              clk,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jtpopeye_objbuf.sv
// Double-buffered object line buffer: the renderer fills the draw bank while the
// display bank is read out at pixel rate and erased behind the read pointer.
module jtpopeye_objbuf
  import jtpopeye_pkg::*;
#(
  parameter int AW = OBJ_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl2_cen,
  input  logic              HB_n,
  input  logic              VB_n,
  input  logic [AW-1:0]     rd_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [OBJ_DW-1:0] wr_data,
  output logic              wr_ready,
  output logic [5:0]        objc,
  output logic [1:0]        objv
);

  objbuf_state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          bank_sel, hb_l;

  logic [AW-1:0]     bk_raddr [2];
  logic [OBJ_DW-1:0] bk_rdata [2];
  logic              bk_we    [2];
  logic [AW-1:0]     bk_waddr [2];
  logic [OBJ_DW-1:0] bk_wdata [2];

  // write pipeline: p0 = op issued last clk, RAM word now valid; p1 = last landed write
  logic              vld_p0, wr_bank_p0;
  logic [AW-1:0]     wr_addr_p0;
  logic [OBJ_DW-1:0] wr_data_p0, stored_p0;
  logic              rmw_we;
  logic              fwd_vld_p1, fwd_bank_p1;
  logic [AW-1:0]     fwd_addr_p1;
  logic [OBJ_DW-1:0] fwd_data_p1;

  // display pipeline: p0 = sample taken on pxl2_cen; p1 = captured RAM word
  logic              rd_vld_p0, rd_bank_p0, blank_p0;
  logic [AW-1:0]     rd_addr_p0;
  logic [OBJ_DW-1:0] disp_p1;
  logic              erase_we;

  assign wr_ready = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // HB_n falling edge, seen at pixel rate, swaps display and draw banks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_l     <= 1'b1;
      bank_sel <= 1'b0;
    end else if (pxl2_cen) begin
      hb_l <= HB_n;
      if (hb_l && !HB_n) bank_sel <= ~bank_sel;
    end
  end

  // Stage 0 -> stage 1: draw-bank RMW, first-written sprite wins
  assign stored_p0 = (fwd_vld_p1 && fwd_addr_p1 == wr_addr_p0 && fwd_bank_p1 == wr_bank_p0)
                     ? fwd_data_p1 : bk_rdata[wr_bank_p0];
  assign rmw_we    = vld_p0 && obj_pxl_v(wr_data_p0) != 2'd0 && obj_pxl_v(stored_p0) == 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      fwd_vld_p1 <= 1'b0;
    end else begin
      vld_p0     <= wr_en && wr_ready;
      fwd_vld_p1 <= rmw_we;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_p0  <= wr_addr;
    wr_data_p0  <= wr_data;
    wr_bank_p0  <= ~bank_sel;
    fwd_addr_p1 <= wr_addr_p0;
    fwd_data_p1 <= wr_data_p0;
    fwd_bank_p1 <= wr_bank_p0;
  end

  // Display read: sample on pxl2_cen, capture word next clk, present on next pxl2_cen
  assign erase_we = rd_vld_p0 && !blank_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p0 <= 1'b0;
      blank_p0  <= 1'b1;
      objc      <= '0;
      objv      <= '0;
    end else begin
      rd_vld_p0 <= pxl2_cen;
      if (pxl2_cen) blank_p0 <= !(HB_n && VB_n) || state != RUN;
      if (state == CLEAR) begin
        objc <= '0;
        objv <= '0;
      end else if (pxl2_cen) begin
        {objc, objv} <= blank_p0 ? '0 : disp_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pxl2_cen) begin
      rd_addr_p0 <= rd_addr;
      rd_bank_p0 <= bank_sel;
    end
    if (rd_vld_p0) disp_p1 <= bk_rdata[rd_bank_p0];
  end

  // Port routing: display bank reads the pixel address, draw bank the renderer address.
  // Write ops target their latched bank, so RMW and erase never share a bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bk_raddr[b] = (bank_sel == 1'(b)) ? rd_addr : wr_addr;
      bk_we[b]    = 1'b0;
      bk_waddr[b] = wr_addr_p0;
      bk_wdata[b] = wr_data_p0;
      if (state == CLEAR) begin
        bk_we[b]    = 1'b1;
        bk_waddr[b] = cnt;
        bk_wdata[b] = '0;
      end else if (rmw_we && wr_bank_p0 == 1'(b)) begin
        bk_we[b] = 1'b1;
      end else if (erase_we && rd_bank_p0 == 1'(b)) begin
        bk_we[b]    = 1'b1;
        bk_waddr[b] = rd_addr_p0;
        bk_wdata[b] = '0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jtpopeye_objbuf_bank #(
      .AW     (AW),
      .DATA_W (OBJ_DW)
    ) u_bank (
      .clk     (clk),
      .rd_addr (bk_raddr[g]),
      .rd_data (bk_rdata[g]),
      .wr_en   (bk_we[g]),
      .wr_addr (bk_waddr[g]),
      .wr_data (bk_wdata[g])
    );
  end

endmodule
